// File: rtl/fib_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Valid/ready handshake on both sides; reports the count of significant digits.
module fib_bcd_converter #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10,
  parameter int CNTW   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [3:0]            ndigits
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state;
  logic [WIDTH-1:0]    shreg;
  logic [4*DIGITS-1:0] acc;
  logic [CNTW-1:0]     cnt;

  logic [4*DIGITS-1:0] acc_adj;
  logic [4*DIGITS-1:0] acc_nxt;
  logic [WIDTH-1:0]    sh_nxt;
  logic [3:0]          nd_nxt;

  assign in_ready = (state == IDLE);

  // One double-dabble step: add 3 to every digit >= 5, then shift {acc, shreg} left.
  always_comb begin
    acc_adj = acc;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5)
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    {acc_nxt, sh_nxt} = {acc_adj, shreg} << 1;
    nd_nxt = 4'd1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc_nxt[4*i +: 4] != 4'd0)
        nd_nxt = 4'(i + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      bcd       <= '0;
      ndigits   <= '0;
      cnt       <= '0;
      shreg     <= '0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg <= in_bin;
            acc   <= '0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc   <= acc_nxt;
          shreg <= sh_nxt;
          cnt   <= cnt + 1'b1;
          if (cnt == CNTW'(WIDTH - 1)) begin
            bcd       <= acc_nxt;
            ndigits   <= nd_nxt;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
